// File: rtl/tt_um_islam_ihfaz_d_latch.sv
// rtl/tt_um_islam_ihfaz_d_latch.sv - clock-synchronous 8-bit D latch bank emulation tile
module tt_um_islam_ihfaz_d_latch #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] ui_in,
    input  logic [7:0]       uio_in,
    output logic [WIDTH-1:0] uo_out,
    output logic [7:0]       uio_out,
    output logic [7:0]       uio_oe
);

    typedef enum logic [1:0] {
        MODE_TRANSP_HIGH = 2'b00,
        MODE_TRANSP_LOW  = 2'b01,
        MODE_RISE_CAP    = 2'b10,
        MODE_FALL_CAP    = 2'b11
    } mode_e;

    logic             gate;
    mode_e            mode;
    logic             inv;
    logic             clr;

    logic [WIDTH-1:0] q_q, q_d;
    logic             g_prev_q, g_prev_d;

    assign gate = uio_in[0];
    assign mode = mode_e'(uio_in[2:1]);
    assign inv  = uio_in[3];
    assign clr  = uio_in[4];

    // ena and the reserved control bits are deliberately ignored
    logic unused_ok;
    assign unused_ok = ^{ena, uio_in[7:5]};

    // next-state: clear wins over every mode; the gate history always follows G
    always_comb begin
        q_d      = q_q;
        g_prev_d = gate;
        if (clr) begin
            q_d = '0;
        end else begin
            unique case (mode)
                MODE_TRANSP_HIGH: if (gate)              q_d = ui_in;
                MODE_TRANSP_LOW:  if (!gate)             q_d = ui_in;
                MODE_RISE_CAP:    if (gate && !g_prev_q) q_d = ui_in;
                MODE_FALL_CAP:    if (!gate && g_prev_q) q_d = ui_in;
                default:          q_d = q_q;
            endcase
        end
    end

    // state registers; reset seeds the gate history with the live G so no edge is seen on release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q      <= '0;
            g_prev_q <= gate;
        end else begin
            q_q      <= q_d;
            g_prev_q <= g_prev_d;
        end
    end

    // output inversion is combinational so INV acts without a clock
    assign uo_out  = q_q ^ {WIDTH{inv}};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_islam_ihfaz_d_latch.sv
// tb/tb_tt_um_islam_ihfaz_d_latch.sv - scoreboard testbench for the D latch bank tile
module tb_tt_um_islam_ihfaz_d_latch;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic [7:0] m_q;
    logic       m_gprev;

    tt_um_islam_ihfaz_d_latch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl(input logic g, input logic [1:0] mode,
                                       input logic inv, input logic clr, input logic [2:0] res);
        return {res, clr, inv, mode, g};
    endfunction

    // drive one cycle of stimulus, push the model's post-edge output, then compare after the edge
    task automatic cycle(input string tag, input logic rstn, input logic [7:0] d,
                         input logic [7:0] c, input logic glitch);
        logic       g;
        logic [1:0] mode;
        logic [7:0] exp;
        rst_n  = rstn;
        ui_in  = d;
        uio_in = c;
        g      = c[0];
        mode   = c[2:1];
        if (!rstn) begin
            m_q = 8'h00;
        end else if (c[4]) begin
            m_q = 8'h00;
        end else begin
            case (mode)
                2'b00: if (g)             m_q = d;
                2'b01: if (!g)            m_q = d;
                2'b10: if (g && !m_gprev) m_q = d;
                2'b11: if (!g && m_gprev) m_q = d;
                default: ;
            endcase
        end
        m_gprev = g;
        exp = m_q ^ {8{c[3]}};
        exp_q.push_back(exp);
        if (glitch) begin
            #1 uio_in[0] = ~g;
            #2 uio_in[0] = g;
        end
        @(posedge clk);
        #1;
        check_eq(tag, uo_out, exp_q.pop_front());
        check_eq({tag, "_uio_out"}, uio_out, 8'h00);
        check_eq({tag, "_uio_oe"}, uio_oe, 8'h00);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_q      = 8'h00;
        m_gprev  = 1'b0;
        ena      = 1'b1;
        rst_n    = 1'b0;
        ui_in    = 8'h00;
        uio_in   = 8'h00;
        @(posedge clk);
        #1;

        // reset and release
        cycle("rst0", 1'b0, 8'hA5, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        cycle("rst1", 1'b0, 8'hA5, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        check_eq("rst_literal", uo_out, 8'h00);
        cycle("rel", 1'b1, 8'hA5, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        check_eq("rel_literal", uo_out, 8'hA5);

        // transparent-high
        cycle("th_3c", 1'b1, 8'h3C, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        cycle("th_c3", 1'b1, 8'hC3, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        cycle("th_hold", 1'b1, 8'hFF, ctl(0, 2'b00, 0, 0, 3'b000), 0);
        check_eq("th_hold_literal", uo_out, 8'hC3);
        cycle("th_open", 1'b1, 8'hFF, ctl(1, 2'b00, 0, 0, 3'b000), 0);

        // transparent-low
        cycle("tl_55", 1'b1, 8'h55, ctl(0, 2'b01, 0, 0, 3'b000), 0);
        cycle("tl_hold", 1'b1, 8'hAA, ctl(1, 2'b01, 0, 0, 3'b000), 0);
        check_eq("tl_hold_literal", uo_out, 8'h55);

        // edge capture
        cycle("rc_low", 1'b1, 8'h12, ctl(0, 2'b10, 0, 0, 3'b000), 0);
        cycle("rc_rise", 1'b1, 8'h34, ctl(1, 2'b10, 0, 0, 3'b000), 0);
        check_eq("rc_rise_literal", uo_out, 8'h34);
        cycle("rc_held", 1'b1, 8'h56, ctl(1, 2'b10, 0, 0, 3'b000), 0);
        cycle("fc_high", 1'b1, 8'h56, ctl(1, 2'b11, 0, 0, 3'b000), 0);
        cycle("fc_fall", 1'b1, 8'h78, ctl(0, 2'b11, 0, 0, 3'b000), 0);
        check_eq("fc_fall_literal", uo_out, 8'h78);

        // clear priority
        cycle("clr0", 1'b1, 8'h99, ctl(1, 2'b00, 0, 1, 3'b000), 0);
        cycle("clr1", 1'b1, 8'h99, ctl(1, 2'b00, 0, 1, 3'b000), 0);
        cycle("clr_off", 1'b1, 8'h99, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        check_eq("clr_off_literal", uo_out, 8'h99);

        // immediate invert
        cycle("q0f", 1'b1, 8'h0F, ctl(1, 2'b00, 0, 0, 3'b000), 0);
        uio_in = ctl(1, 2'b00, 1, 0, 3'b000);
        #1;
        exp_q.push_back(m_q ^ 8'hFF);
        check_eq("inv_now", uo_out, exp_q.pop_front());
        check_eq("inv_now_literal", uo_out, 8'hF0);

        // reset with G high in rising-capture mode: no capture on release
        cycle("rrc0", 1'b0, 8'hAB, ctl(1, 2'b10, 1, 0, 3'b000), 0);
        cycle("rrc_rel", 1'b1, 8'hAB, ctl(1, 2'b10, 1, 0, 3'b000), 0);
        check_eq("rrc_rel_literal", uo_out, 8'hFF);
        cycle("rrc_held", 1'b1, 8'hCD, ctl(1, 2'b10, 1, 0, 3'b000), 0);

        // short glitch on G between edges is ignored
        cycle("gl_low", 1'b1, 8'h11, ctl(0, 2'b10, 0, 0, 3'b000), 0);
        cycle("gl_pulse", 1'b1, 8'h22, ctl(0, 2'b10, 0, 0, 3'b000), 1);
        check_eq("gl_pulse_literal", uo_out, 8'h00);

        // mode switch into an edge mode with a pending rising edge captures
        cycle("sw_low", 1'b1, 8'h44, ctl(0, 2'b01, 0, 0, 3'b111), 0);
        cycle("sw_rise", 1'b1, 8'h66, ctl(1, 2'b10, 0, 0, 3'b101), 0);
        check_eq("sw_rise_literal", uo_out, 8'h66);

        // random traffic with reserved bits and ena toggling
        for (int i = 0; i < 40; i++) begin
            ena = 1'($urandom_range(0, 1));
            cycle("rand", ($urandom_range(0, 15) != 0), 8'($urandom), 8'($urandom) & 8'hEF | ($urandom_range(0, 9) == 0 ? 8'h10 : 8'h00), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
